// File: rtl/if_id_ctrl_pkg.sv
// Shared defines for the IF/ID pipeline controller: widths, state encodings,
// the NOP opcode loaded by a flush, and the control-bundle payload.
package if_id_ctrl_pkg;

    localparam int unsigned REG_W    = 3;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned OPCODE_W = 6;

    // Opcode that IF/ID presents downstream after a flush.
    localparam logic [OPCODE_W-1:0] NOP_OPCODE = 6'h00;

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_IMEM_WAIT = 2'b01,
        ST_HALTED    = 2'b10
    } state_e;

    typedef struct packed {
        logic pc_wr_en;
        logic if_id_wr_en;
        logic if_id_flush;
        logic id_ex_bubble;
    } ctrl_t;

endpackage

// File: rtl/if_id_ctrl_hazard_detect.sv
// Load-use hazard detection between the load in EX and the sources read in ID.
module hazard_detect
    import if_id_ctrl_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    output logic             load_use_c
);

    assign load_use_c = ex_mem_read &
                        ((id_rs_used & (id_rs == ex_rd)) |
                         (id_rt_used & (id_rt == ex_rd)));

endmodule

// File: rtl/if_id_ctrl.sv
// IF/ID stage controller: PC/IF-ID write enables, flush and bubble generation
// for redirects, load-use stalls, instruction-fetch waits and HALT.
module if_id_ctrl
    import if_id_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             redirect,
    input  logic             imem_done,
    input  logic             halt_id,
    input  logic             err_in,
    output logic             pc_wr_en,
    output logic             if_id_wr_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic             err_out,
    output logic [CNT_W-1:0] stall_count
);

    logic             load_use;
    state_e           state_q;
    state_e           state_d;
    logic             pend_q;
    logic             pend_d;
    logic [CNT_W-1:0] stall_q;
    logic             err_q;
    logic             illegal;
    ctrl_t            ctrl;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .load_use_c  (load_use)
    );

    // State, pending-flush, stall counter and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (!if_id_wr_en && (state_q != ST_HALTED) && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            err_q <= err_q | err_in | illegal;
        end
    end

    // Next state and control outputs; priority redirect > load_use > halt > fetch.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ctrl    = '0;
        illegal = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    ctrl.pc_wr_en     = 1'b1;
                    ctrl.if_id_wr_en  = 1'b1;
                    ctrl.if_id_flush  = 1'b1;
                    ctrl.id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    ctrl.id_ex_bubble = 1'b1;
                end else if (halt_id) begin
                    state_d = ST_HALTED;
                end else if (imem_done) begin
                    ctrl.pc_wr_en    = 1'b1;
                    ctrl.if_id_wr_en = 1'b1;
                end else begin
                    state_d = ST_IMEM_WAIT;
                end
            end
            ST_IMEM_WAIT: begin
                if (redirect) begin
                    ctrl.pc_wr_en     = 1'b1;
                    ctrl.id_ex_bubble = 1'b1;
                    if (imem_done) begin
                        ctrl.if_id_wr_en = 1'b1;
                        ctrl.if_id_flush = 1'b1;
                        pend_d           = 1'b0;
                        state_d          = ST_RUN;
                    end else begin
                        pend_d = 1'b1;
                    end
                end else if (load_use) begin
                    ctrl.id_ex_bubble = 1'b1;
                end else if (halt_id && !pend_q) begin
                    // A HALT behind a pending redirect is wrong-path and ignored.
                    state_d = ST_HALTED;
                end else if (imem_done) begin
                    // PC already holds the redirect target when a flush is pending.
                    ctrl.pc_wr_en    = ~pend_q;
                    ctrl.if_id_wr_en = 1'b1;
                    ctrl.if_id_flush = pend_q;
                    pend_d           = 1'b0;
                    state_d          = ST_RUN;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                illegal = 1'b1;
                pend_d  = 1'b0;
                state_d = ST_HALTED;
            end
        endcase
    end

    // Reset forces a NOP into IF/ID while holding the PC.
    assign pc_wr_en     = rst & ctrl.pc_wr_en;
    assign if_id_wr_en  = ~rst | ctrl.if_id_wr_en;
    assign if_id_flush  = ~rst | ctrl.if_id_flush;
    assign id_ex_bubble = ~rst | ctrl.id_ex_bubble;
    assign halted       = rst & (state_q == ST_HALTED);
    assign err_out      = err_q;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_if_id_ctrl.sv
// Randomized + directed bench for if_id_ctrl against a rule-level reference model.
module tb_if_id_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [2:0]  ex_rd = 3'd0;
    logic [2:0]  id_rs = 3'd0;
    logic [2:0]  id_rt = 3'd0;
    logic        id_rs_used = 1'b0;
    logic        id_rt_used = 1'b0;
    logic        redirect = 1'b0;
    logic        imem_done = 1'b1;
    logic        halt_id = 1'b0;
    logic        err_in = 1'b0;
    logic        pc_wr_en;
    logic        if_id_wr_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        halted;
    logic        err_out;
    logic [15:0] stall_count;

    int vectors = 0;
    int errs = 0;

    if_id_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .redirect     (redirect),
        .imem_done    (imem_done),
        .halt_id      (halt_id),
        .err_in       (err_in),
        .pc_wr_en     (pc_wr_en),
        .if_id_wr_en  (if_id_wr_en),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .halted       (halted),
        .err_out      (err_out),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: is the pipe halted, is a fetch outstanding, is a flush owed.
    bit m_halt = 0, m_wait = 0, m_pend = 0, m_err = 0;
    int m_stalls = 0;
    bit n_halt, n_wait, n_pend, n_err;
    int n_stalls;

    always @(negedge clk) begin
        bit lu, pc, wr, fl, bub;
        lu = ex_mem_read && ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
        pc = 0; wr = 0; fl = 0; bub = 0;
        n_halt = m_halt; n_wait = m_wait; n_pend = m_pend;
        n_err = m_err | err_in;
        if (!rst) begin
            wr = 1; fl = 1; bub = 1;
        end else if (m_halt) begin
            // frozen
        end else if (redirect) begin
            pc = 1; bub = 1;
            fl = !m_wait || imem_done;
            wr = fl;
            n_wait = m_wait && !imem_done;
            n_pend = n_wait;
        end else if (lu) begin
            bub = 1;
        end else if (halt_id && !m_pend) begin
            n_halt = 1;
        end else if (imem_done) begin
            wr = 1; pc = !m_pend; fl = m_pend;
            n_wait = 0; n_pend = 0;
        end else begin
            n_wait = 1;
        end
        n_stalls = (!wr && !m_halt && m_stalls < 16'hFFFF) ? m_stalls + 1 : m_stalls;
        chk("pc_wr_en",     16'(pc_wr_en),     16'(pc));
        chk("if_id_wr_en",  16'(if_id_wr_en),  16'(wr));
        chk("if_id_flush",  16'(if_id_flush),  16'(fl));
        chk("id_ex_bubble", 16'(id_ex_bubble), 16'(bub));
        chk("halted",       16'(halted),       16'(rst && m_halt));
        chk("err_out",      16'(err_out),      16'(m_err));
        chk("stall_count",  stall_count,       16'(m_stalls));
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_halt <= 0; m_wait <= 0; m_pend <= 0; m_err <= 0; m_stalls <= 0;
        end else begin
            m_halt <= n_halt; m_wait <= n_wait; m_pend <= n_pend;
            m_err <= n_err; m_stalls <= n_stalls;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        ex_mem_read = 0; id_rs_used = 0; id_rt_used = 0;
        redirect = 0; imem_done = 1; halt_id = 0; err_in = 0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_pc"},    16'(pc_wr_en),     16'd0);
        chk({tag, "_wr"},    16'(if_id_wr_en),  16'd1);
        chk({tag, "_fl"},    16'(if_id_flush),  16'd1);
        chk({tag, "_bub"},   16'(id_ex_bubble), 16'd1);
        chk({tag, "_halt"},  16'(halted),       16'd0);
        chk({tag, "_stall"}, stall_count,       16'd0);
    endtask

    initial begin
        idle();
        smp();
        chk_reset_outs("rst");
        chk("rst_err", 16'(err_out), 16'd0);
        cyc(); rst = 1;
        smp();
        chk("run_pc", 16'(pc_wr_en), 16'd1);
        chk("run_wr", 16'(if_id_wr_en), 16'd1);

        // Load-use on rs
        cyc(); ex_mem_read = 1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_used = 1;
        smp();
        chk("lu_pc", 16'(pc_wr_en), 16'd0);
        chk("lu_wr", 16'(if_id_wr_en), 16'd0);
        chk("lu_bub", 16'(id_ex_bubble), 16'd1);
        chk("lu_stall0", stall_count, 16'd0);
        cyc(); idle();
        smp();
        chk("lu_stall1", stall_count, 16'd1);
        chk("lu_after_bub", 16'(id_ex_bubble), 16'd0);

        // Redirect in RUN
        cyc(); redirect = 1;
        smp();
        chk("rd_fl", 16'(if_id_flush), 16'd1);
        chk("rd_pc", 16'(pc_wr_en), 16'd1);
        chk("rd_wr", 16'(if_id_wr_en), 16'd1);
        cyc(); idle();
        smp();
        chk("rd_nostall", stall_count, 16'd1);

        // Redirect during a fetch wait
        cyc(); rst = 0;
        cyc(); rst = 1; imem_done = 0;
        smp();
        chk("fw1_pc", 16'(pc_wr_en), 16'd0);
        chk("fw1_wr", 16'(if_id_wr_en), 16'd0);
        cyc(); redirect = 1;
        smp();
        chk("fw2_pc", 16'(pc_wr_en), 16'd1);
        chk("fw2_fl", 16'(if_id_flush), 16'd0);
        cyc(); redirect = 0;
        smp();
        chk("fw3_wr", 16'(if_id_wr_en), 16'd0);
        cyc(); imem_done = 1;
        smp();
        chk("fw_done_fl", 16'(if_id_flush), 16'd1);
        chk("fw_done_wr", 16'(if_id_wr_en), 16'd1);
        chk("fw_done_pc", 16'(pc_wr_en), 16'd0);
        chk("fw_stall3", stall_count, 16'd3);
        cyc();
        smp();
        chk("fw_clr_fl", 16'(if_id_flush), 16'd0);
        chk("fw_clr_pc", 16'(pc_wr_en), 16'd1);
        chk("fw_stall3b", stall_count, 16'd3);

        // Halt on wrong path, then real halt
        cyc(); halt_id = 1; redirect = 1;
        smp();
        chk("hw_halt", 16'(halted), 16'd0);
        cyc(); idle();
        smp();
        chk("hw_halt_next", 16'(halted), 16'd0);
        cyc(); halt_id = 1;
        smp();
        chk("h_now", 16'(halted), 16'd0);
        cyc(); halt_id = 0;
        for (int k = 0; k < 10; k++) begin
            smp();
            chk("h_held", 16'(halted), 16'd1);
            chk("h_pc", 16'(pc_wr_en), 16'd0);
            chk("h_wr", 16'(if_id_wr_en), 16'd0);
            cyc();
        end

        // Sticky error, cleared asynchronously
        rst = 0;
        cyc(); rst = 1; err_in = 1;
        smp();
        chk("err_same", 16'(err_out), 16'd0);
        cyc(); err_in = 0;
        smp();
        chk("err_next", 16'(err_out), 16'd1);
        cyc();
        smp();
        chk("err_sticky", 16'(err_out), 16'd1);
        #1 rst = 0;
        #1 chk("err_async_clr", 16'(err_out), 16'd0);

        // Async reset mid fetch wait
        cyc(); rst = 1; imem_done = 0;
        smp();
        chk("aw_wr", 16'(if_id_wr_en), 16'd0);
        cyc();
        smp();
        #1 rst = 0;
        #1 chk_reset_outs("aw_rst");
        cyc(); rst = 1; imem_done = 1;
        smp();
        chk("aw_run_pc", 16'(pc_wr_en), 16'd1);
        chk("aw_run_fl", 16'(if_id_flush), 16'd0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (!rst) begin
                if ($urandom_range(0, 1) == 0) rst = 1;
            end else if ($urandom_range(0, 39) == 0) begin
                rst = 0;
            end
            ex_mem_read = ($urandom_range(0, 3) == 0);
            ex_rd       = 3'($urandom_range(0, 3));
            id_rs       = 3'($urandom_range(0, 3));
            id_rt       = 3'($urandom_range(0, 3));
            id_rs_used  = 1'($urandom_range(0, 1));
            id_rt_used  = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 7) == 0);
            imem_done   = ($urandom_range(0, 2) != 0);
            halt_id     = ($urandom_range(0, 29) == 0);
            err_in      = ($urandom_range(0, 59) == 0);
            if (rst && $urandom_range(0, 79) == 0) begin
                #3 rst = 0;
            end
        end

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/if_id_ctrl.md
IF_ID_CTRL -- requirements
Module: if_id_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port ex_mem_read, input, 1, instruction in EX is a load.
REQ-004 SHALL have port ex_rd, input, 3, destination register of the instruction in EX.
REQ-005 SHALL have ports id_rs/id_rt, input, 3 each, source registers of the instruction in ID.
REQ-006 SHALL have ports id_rs_used/id_rt_used, input, 1 each, the matching source is read.
REQ-007 SHALL have port redirect, input, 1, branch/jump resolved taken in EX this cycle.
REQ-008 SHALL have port imem_done, input, 1, instruction fetch completes this cycle.
REQ-009 SHALL have port halt_id, input, 1, HALT decoded in ID.
REQ-010 SHALL have port err_in, input, 1, error from the IF/ID register or the fetch stage.
REQ-011 SHALL have outputs pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble, halted, err_out, all 1 bit.
REQ-012 SHALL have output stall_count, 16 bits, cycles in which if_id_wr_en was 0 outside HALTED.

Function
REQ-013 SHALL implement states RUN, IMEM_WAIT and HALTED, with a 1-bit pend_flush flag.
REQ-014 SHALL define load_use = ex_mem_read & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
REQ-015 SHALL apply priority redirect > load_use > halt_id > fetch wait.
REQ-016 SHALL, in RUN with redirect=1, drive pc_wr_en=1, if_id_wr_en=1, if_id_flush=1 and id_ex_bubble=1 in the same cycle.
REQ-017 SHALL, in RUN with load_use=1 and redirect=0, drive pc_wr_en=0, if_id_wr_en=0 and id_ex_bubble=1 for one cycle only.
REQ-018 SHALL, in RUN with imem_done=0 and no redirect, enter IMEM_WAIT next cycle with pc_wr_en=0 and if_id_wr_en=0.
REQ-019 SHALL, in IMEM_WAIT, hold pc_wr_en=0 and if_id_wr_en=0 until imem_done=1, then return to RUN.
REQ-020 SHALL, on the imem_done cycle in IMEM_WAIT, assert if_id_wr_en=1.
REQ-021 SHALL, on the imem_done cycle in IMEM_WAIT, assert if_id_flush=1 when pend_flush=1, then clear pend_flush.
REQ-022 SHALL, if redirect arrives in IMEM_WAIT, set pend_flush and assert pc_wr_en=1 for that cycle to load the target.
REQ-023 SHALL, on redirect and imem_done in the same IMEM_WAIT cycle, flush immediately and leave pend_flush clear.
REQ-024 SHALL, on halt_id=1 with redirect=0 and load_use=0, enter HALTED next cycle.
REQ-025 SHALL ignore halt_id when redirect=1, because that HALT is on the wrong path.
REQ-026 SHALL, in HALTED, hold pc_wr_en=0, if_id_wr_en=0 and halted=1, leaving only on reset.
REQ-027 SHALL increment stall_count by 1 on each cycle with if_id_wr_en=0 outside HALTED, saturating at 16'hFFFF.
REQ-028 SHALL register err_out sticky: set the cycle after err_in=1 or an illegal state encoding is reached.
REQ-029 SHALL force the next state to HALTED on an illegal state encoding.
REQ-030 SHALL make all control outputs combinational from state, pend_flush and inputs; there is zero added latency.

Reset
REQ-031 SHALL, while rst=0, force state RUN, pend_flush=0, stall_count=0 and err_out=0 asynchronously.
REQ-032 SHALL, while rst=0, drive pc_wr_en=0, if_id_wr_en=1, if_id_flush=1, id_ex_bubble=1 and halted=0, loading a NOP.
REQ-033 SHALL, on reset asserted mid-IMEM_WAIT or in HALTED, discard pending state and resume in RUN after release.

Structure
REQ-034 SHALL take state encodings and the NOP opcode constant from the team's shared defines include file.
REQ-035 SHALL contain one sub-module, hazard_detect, that is combinational and computes load_use.

Verification
REQ-036 Load-use: ex_mem_read=1, ex_rd=3, id_rs=3, id_rs_used=1 -> one cycle of pc_wr_en=0, if_id_wr_en=0, id_ex_bubble=1, and stall_count 0->1.
REQ-037 Redirect: redirect=1 in RUN -> same-cycle if_id_flush=1 and pc_wr_en=1, with no stall.
REQ-038 Flush during wait: imem_done=0 for 3 cycles with redirect on the 2nd, then imem_done=1 -> flush on the done cycle, pend_flush cleared, stall_count=3.
REQ-039 Halt: halt_id=1 with redirect=1 -> no halt; halt_id=1 alone -> halted=1 next cycle, held for 10 cycles.
REQ-040 Error: err_in pulsed 1 cycle -> err_out=1 from the next cycle until rst=0, cleared asynchronously.
REQ-041 Async reset mid-IMEM_WAIT: rst=0 between clock edges -> outputs take reset values immediately, then RUN after release.
